edu_token_scheduler: RTL and testbench



---
 rtl/edu_token_scheduler_pkg.sv | 12 +
 rtl/edu_token_prienc.sv | 31 +++
 rtl/edu_token_scheduler.sv | 98 +++++++++
 tb/tb_edu_token_scheduler.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/edu_token_scheduler_pkg.sv
// Shared sizing defaults and FSM encoding for the token scheduler slice.
package edu_token_scheduler_pkg;

  localparam int NUM_AQROW    = 4;
  localparam int NUM_AQCOL    = 4;
  localparam int TKROWADDR_BW = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/edu_token_prienc.sv
// Rotating priority encoder: first set bit of vec searching start..N-1, then 0..start-1.
module edu_token_prienc #(
  parameter int N  = 7,
  parameter int AW = 3
) (
  input  logic [N-1:0]  vec,
  input  logic [AW-1:0] start,
  output logic          found,
  output logic [AW-1:0] idx,
  output logic [N-1:0]  onehot
);

  int p;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    p      = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(start) + k;
      if (p >= N) p = p - N;
      if (!found && vec[p]) begin
        found     = 1'b1;
        idx       = AW'(p);
        onehot[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/edu_token_scheduler.sv
// Batch token scheduler: loads a row-occupancy vector and grants up to NUM_CH rows per handshake.
module edu_token_scheduler
  import edu_token_scheduler_pkg::*;
#(
  parameter int NUM_ROWS   = NUM_AQROW + NUM_AQCOL - 1,
  parameter int ROWADDR_BW = TKROWADDR_BW,
  parameter int NUM_CH     = 1,
  parameter int RR_MODE    = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [NUM_ROWS-1:0]            token_exist_rows_in,
  input  logic                           flush,
  output logic                           token_valid,
  input  logic                           token_ready,
  output logic [NUM_CH*NUM_ROWS-1:0]     token_grant_onehot,
  output logic [NUM_CH-1:0]              token_ch_valid,
  output logic [NUM_CH*ROWADDR_BW-1:0]   token_row,
  output logic                           done,
  output logic                           busy
);

  logic [1:0]                            state;
  logic [NUM_ROWS-1:0]                   pending;
  logic [ROWADDR_BW-1:0]                 rr_ptr, start, last_idx, next_ptr;
  logic [NUM_CH:0][NUM_ROWS-1:0]         mask;
  logic [NUM_CH-1:0][NUM_ROWS-1:0]       oh;
  logic [NUM_CH-1:0][ROWADDR_BW-1:0]     idx;
  logic [NUM_CH-1:0]                     found;
  logic [NUM_CH-1:0][NUM_ROWS-1:0]       oh_q;
  logic [NUM_CH-1:0][ROWADDR_BW-1:0]     idx_q;
  logic                                  issue, accept;

  assign issue = (state == ST_ISSUE);
  assign start = (RR_MODE != 0) ? rr_ptr : '0;

  // Each encoder sees pending minus all earlier channels' picks, so channels
  // walk forward in search order without duplicates.
  assign mask[0] = pending;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    edu_token_prienc #(.N(NUM_ROWS), .AW(ROWADDR_BW)) u_enc (
      .vec    (mask[c]),
      .start  (start),
      .found  (found[c]),
      .idx    (idx[c]),
      .onehot (oh[c])
    );
    assign mask[c+1] = mask[c] & ~oh[c];
    assign oh_q[c]   = token_ch_valid[c] ? oh[c]  : '0;
    assign idx_q[c]  = token_ch_valid[c] ? idx[c] : '0;
  end

  assign token_valid        = issue && (|pending);
  assign token_ch_valid     = issue ? found : '0;
  assign token_grant_onehot = oh_q;
  assign token_row          = idx_q;
  assign accept             = token_valid && token_ready;

  always_comb begin
    last_idx = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (found[c]) last_idx = idx[c];
  end

  assign next_ptr = (last_idx == ROWADDR_BW'(NUM_ROWS - 1)) ? '0 : last_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pending <= '0;
      rr_ptr  <= '0;
    end else if (flush) begin
      state   <= ST_IDLE;
      pending <= '0;
    end else begin
      case (state)
        ST_IDLE: if (load_valid) begin
          pending <= token_exist_rows_in;
          state   <= (|token_exist_rows_in) ? ST_ISSUE : ST_DONE;
        end
        ST_ISSUE: if (accept) begin
          pending <= mask[NUM_CH];
          rr_ptr  <= next_ptr;
          if (mask[NUM_CH] == '0) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign load_ready = (state == ST_IDLE);
  assign done       = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_edu_token_scheduler.sv
// Directed bench: three scheduler configurations (1ch fixed, 2ch fixed, 1ch round-robin), 7 rows.
module tb_edu_token_scheduler;

  logic clk = 1'b0;
  logic rst, flush;
  int   errors = 0;
  int   checks = 0;

  logic       a_lv, a_lr, a_tv, a_tr, a_done, a_busy;
  logic [6:0] a_vec, a_oh;
  logic [0:0] a_chv;
  logic [2:0] a_row;

  logic        b_lv, b_lr, b_tv, b_tr, b_done, b_busy;
  logic [6:0]  b_vec;
  logic [13:0] b_oh;
  logic [1:0]  b_chv;
  logic [5:0]  b_row;

  logic       c_lv, c_lr, c_tv, c_tr, c_done, c_busy;
  logic [6:0] c_vec, c_oh;
  logic [0:0] c_chv;
  logic [2:0] c_row;

  always #5 clk = ~clk;

  edu_token_scheduler #(.NUM_ROWS(7), .ROWADDR_BW(3), .NUM_CH(1), .RR_MODE(0)) u_a (
    .clk(clk), .rst(rst), .load_valid(a_lv), .load_ready(a_lr), .token_exist_rows_in(a_vec),
    .flush(flush), .token_valid(a_tv), .token_ready(a_tr), .token_grant_onehot(a_oh),
    .token_ch_valid(a_chv), .token_row(a_row), .done(a_done), .busy(a_busy));

  edu_token_scheduler #(.NUM_ROWS(7), .ROWADDR_BW(3), .NUM_CH(2), .RR_MODE(0)) u_b (
    .clk(clk), .rst(rst), .load_valid(b_lv), .load_ready(b_lr), .token_exist_rows_in(b_vec),
    .flush(flush), .token_valid(b_tv), .token_ready(b_tr), .token_grant_onehot(b_oh),
    .token_ch_valid(b_chv), .token_row(b_row), .done(b_done), .busy(b_busy));

  edu_token_scheduler #(.NUM_ROWS(7), .ROWADDR_BW(3), .NUM_CH(1), .RR_MODE(1)) u_c (
    .clk(clk), .rst(rst), .load_valid(c_lv), .load_ready(c_lr), .token_exist_rows_in(c_vec),
    .flush(flush), .token_valid(c_tv), .token_ready(c_tr), .token_grant_onehot(c_oh),
    .token_ch_valid(c_chv), .token_row(c_row), .done(c_done), .busy(c_busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    a_lv = 0; a_vec = '0; a_tr = 0;
    b_lv = 0; b_vec = '0; b_tr = 0;
    c_lv = 0; c_vec = '0; c_tr = 0;
    step(); step();
    chk("rst_lr", a_lr, 1); chk("rst_tv", a_tv, 0); chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0); chk("rst_b_chv", b_chv, 0); chk("rst_b_row", b_row, 0);
    rst = 1'b1;

    // ascending single-channel sequence
    a_lv = 1; a_vec = 7'b0101100; a_tr = 1;
    step(); a_lv = 0;
    chk("a1_tv", a_tv, 1); chk("a1_row0", a_row, 2); chk("a1_oh0", a_oh, 7'b0000100);
    chk("a1_busy", a_busy, 1);
    step(); chk("a1_row1", a_row, 3);
    step(); chk("a1_row2", a_row, 5); chk("a1_oh2", a_oh, 7'b0100000);
    step(); chk("a1_done", a_done, 1); chk("a1_tv_off", a_tv, 0); chk("a1_lr_lo", a_lr, 0);
    step(); chk("a1_done_off", a_done, 0); chk("a1_lr", a_lr, 1);

    // backpressure for 5 cycles, with an ignored load during ISSUE
    a_lv = 1; a_vec = 7'b0010010; a_tr = 0;
    step();
    chk("bp_row", a_row, 1); chk("bp_oh", a_oh, 7'b0000010);
    a_vec = 7'b1111111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_row", a_row, 1); chk("bp_hold_oh", a_oh, 7'b0000010); chk("bp_hold_tv", a_tv, 1);
    end
    a_lv = 0; a_tr = 1;
    step(); chk("bp_resume_row", a_row, 4); chk("bp_resume_oh", a_oh, 7'b0010000);
    step(); chk("bp_done", a_done, 1);
    step(); chk("bp_lr", a_lr, 1);

    // all-zero load
    a_lv = 1; a_vec = 7'b0;
    step(); a_lv = 0;
    chk("zero_tv", a_tv, 0); chk("zero_done", a_done, 1);
    step(); chk("zero_done_off", a_done, 0); chk("zero_lr", a_lr, 1);

    // flush mid-batch
    a_lv = 1; a_vec = 7'b1000001; a_tr = 0;
    step(); a_lv = 0;
    chk("fl_row", a_row, 0); chk("fl_tv", a_tv, 1);
    flush = 1;
    step(); flush = 0;
    chk("fl_lr", a_lr, 1); chk("fl_tv_off", a_tv, 0); chk("fl_done", a_done, 0); chk("fl_busy", a_busy, 0);
    step(); chk("fl_no_done", a_done, 0);

    // two channels
    b_lv = 1; b_vec = 7'b1110001; b_tr = 1;
    step(); b_lv = 0;
    chk("b1_chv", b_chv, 2'b11); chk("b1_row", b_row, {3'd4, 3'd0});
    chk("b1_oh", b_oh, {7'b0010000, 7'b0000001});
    step();
    chk("b2_chv", b_chv, 2'b11); chk("b2_row", b_row, {3'd6, 3'd5});
    chk("b2_oh", b_oh, {7'b1000000, 7'b0100000});
    step(); chk("b_done", b_done, 1); chk("b_tv_off", b_tv, 0);
    step(); chk("b_lr", b_lr, 1);
    b_lv = 1; b_vec = 7'b0000100;
    step(); b_lv = 0;
    chk("b3_chv", b_chv, 2'b01); chk("b3_row", b_row, {3'd0, 3'd2});
    chk("b3_oh", b_oh, {7'b0000000, 7'b0000100});
    step(); chk("b3_done", b_done, 1);

    // round-robin pointer carried across batches
    c_lv = 1; c_vec = 7'b0000011; c_tr = 1;
    step(); c_lv = 0;
    chk("c1_row0", c_row, 0);
    step(); chk("c1_row1", c_row, 1);
    step(); chk("c1_done", c_done, 1);
    step(); chk("c1_lr", c_lr, 1);
    c_lv = 1; c_vec = 7'b0000101;
    step(); c_lv = 0;
    chk("c2_row0", c_row, 2); chk("c2_oh0", c_oh, 7'b0000100);
    step(); chk("c2_row1", c_row, 0); chk("c2_oh1", c_oh, 7'b0000001);
    step(); chk("c2_done", c_done, 1);
    step();

    // async reset mid-batch
    a_lv = 1; a_vec = 7'b0000110; a_tr = 0;
    step(); a_lv = 0;
    chk("ar_row", a_row, 1); chk("ar_tv", a_tv, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_tv_off", a_tv, 0); chk("ar_row0", a_row, 0); chk("ar_oh0", a_oh, 0);
    chk("ar_chv", a_chv, 0); chk("ar_lr", a_lr, 1); chk("ar_busy", a_busy, 0); chk("ar_done", a_done, 0);
    step(); rst = 1'b1;
    step(); chk("ar_no_done", a_done, 0); chk("ar_idle", a_lr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
